// File: rtl/memory_arbiter_pkg.sv
// Shared encodings for the instruction/data memory arbiter: command, memory
// status, port status codes and arbiter FSM states.
package memory_arbiter_pkg;

    localparam logic [1:0] MEM_NOP   = 2'd0;
    localparam logic [1:0] MEM_READ  = 2'd1;
    localparam logic [1:0] MEM_WRITE = 2'd2;

    localparam logic [1:0] MEM_RESTING  = 2'd0;
    localparam logic [1:0] MEM_WORKING  = 2'd1;
    localparam logic [1:0] MEM_FINISHED = 2'd2;

    localparam logic [1:0] PORT_RESTING  = 2'd0;
    localparam logic [1:0] PORT_WORKING  = 2'd1;
    localparam logic [1:0] PORT_FINISHED = 2'd2;
    localparam logic [1:0] PORT_STALL    = 2'd3;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_e;

    // Owner of an in-flight transaction reports WORKING; completion wins over
    // a fresh request for one cycle; anyone else just reflects its request.
    function automatic logic [1:0] port_status_next(input logic busy,
                                                    input logic done,
                                                    input logic [1:0] sig);
        if (busy) return PORT_WORKING;
        if (done) return PORT_FINISHED;
        if (sig != MEM_NOP) return PORT_STALL;
        return PORT_RESTING;
    endfunction

endpackage

// File: rtl/memory_arbiter_rr_picker.sv
// Two-way round-robin select: on a tie the port that did not win last time
// is chosen. Index 0 is the instruction port, 1 the data port.
module rr_picker_2 (
    input  logic [1:0] elig,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_idx
);

    always_comb begin
        grant_valid = |elig;
        grant_idx   = (&elig) ? ~last_grant : elig[1];
    end

endmodule

// File: rtl/memory_arbiter.sv
// Shares one main-memory port between the instruction cache and the
// load/store unit, one outstanding transaction at a time.
//   state    | meaning
//   ST_IDLE  | no transaction; pick a requester when memory is resting
//   ST_ISSUE | command pulse on mem_vis_signal this cycle
//   ST_WAIT  | waiting for mem_status == MEM_FINISHED
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 17,
    parameter int LEN        = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            i_signal,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [LEN-1:0]        i_rdata,
    output logic [1:0]            i_status,
    input  logic [1:0]            d_signal,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [LEN-1:0]        d_wdata,
    output logic [LEN-1:0]        d_rdata,
    output logic [1:0]            d_status,
    output logic [1:0]            mem_vis_signal,
    output logic [ADDR_WIDTH-1:0] mem_vis_addr,
    output logic [LEN-1:0]        mem_write_data,
    input  logic [LEN-1:0]        mem_data,
    input  logic [1:0]            mem_status
);

    arb_state_e state;
    logic       last_grant;
    logic       owner;
    logic [1:0] op;

    logic elig_i, elig_d;
    logic grant_valid, grant_idx;
    logic grant_go, finish_go;
    logic busy_i, busy_d, done_i, done_d;

    // A port still showing FINISHED is not eligible, so its stale request
    // from the completion cycle cannot be granted a second time.
    assign elig_i = (i_signal != MEM_NOP) && (i_status != PORT_FINISHED);
    assign elig_d = (d_signal != MEM_NOP) && (d_status != PORT_FINISHED);

    rr_picker_2 u_picker (
        .elig        ({elig_d, elig_i}),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    assign grant_go  = (state == ST_IDLE) && (mem_status == MEM_RESTING) && grant_valid;
    assign finish_go = (state == ST_WAIT) && (mem_status == MEM_FINISHED);

    assign busy_i = grant_go ? (grant_idx == PORT_I)
                             : ((state != ST_IDLE) && (owner == PORT_I) && !finish_go);
    assign busy_d = grant_go ? (grant_idx == PORT_D)
                             : ((state != ST_IDLE) && (owner == PORT_D) && !finish_go);
    assign done_i = finish_go && (owner == PORT_I);
    assign done_d = finish_go && (owner == PORT_D);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            last_grant     <= PORT_D;
            owner          <= PORT_I;
            op             <= MEM_NOP;
            mem_vis_signal <= MEM_NOP;
            mem_vis_addr   <= '0;
            mem_write_data <= '0;
            i_rdata        <= '0;
            d_rdata        <= '0;
            i_status       <= PORT_RESTING;
            d_status       <= PORT_RESTING;
        end else begin
            i_status <= port_status_next(busy_i, done_i, i_signal);
            d_status <= port_status_next(busy_d, done_d, d_signal);
            case (state)
                ST_IDLE: begin
                    if (grant_go) begin
                        state      <= ST_ISSUE;
                        owner      <= grant_idx;
                        last_grant <= grant_idx;
                        if (grant_idx == PORT_D) begin
                            op             <= d_signal;
                            mem_vis_signal <= d_signal;
                            mem_vis_addr   <= d_addr;
                            mem_write_data <= d_wdata;
                        end else begin
                            // instruction side only ever reads
                            op             <= MEM_READ;
                            mem_vis_signal <= MEM_READ;
                            mem_vis_addr   <= i_addr;
                        end
                    end
                end
                ST_ISSUE: begin
                    mem_vis_signal <= MEM_NOP;
                    state          <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (finish_go) begin
                        state <= ST_IDLE;
                        if (op == MEM_READ) begin
                            if (owner == PORT_D) d_rdata <= mem_data;
                            else                 i_rdata <= mem_data;
                        end
                    end
                end
                default: begin
                    state          <= ST_IDLE;
                    mem_vis_signal <= MEM_NOP;
                end
            endcase
        end
    end

endmodule
